// File: rtl/maple_rx_datapath.sv
// Maple Bus receive datapath: SDCKA/SDCKB bit decoder, one-word hold-back buffer for tlast, end-of-frame detector.
// Optional feature macro: MAPLE_END_ERR_EN (distinct end_frame_error pulse for a count of 3 or more B falls).
module maple_rx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    enable,
  input  logic                    sdcka_data,
  input  logic                    sdcka_posedge,
  input  logic                    sdcka_negedge,
  input  logic                    sdckb_data,
  input  logic                    sdckb_negedge,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    end_frame,
  output logic                    end_frame_error
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  word_stb_r;
  logic                  enable_q_r;
  logic [DATA_WIDTH-1:0] pend_data_r;
  logic                  pend_valid_r;
  logic [DATA_WIDTH-1:0] m_tdata_r;
  logic                  m_tvalid_r;
  logic                  m_tlast_r;
  logic [KEEP_W-1:0]     m_tstrb_r;
  logic                  armed_r;
  logic [1:0]            end_cnt_r;
  logic                  end_frame_r;
  logic                  end_frame_error_r;

  logic [DATA_WIDTH-1:0] shift_b_s;
  logic [DATA_WIDTH-1:0] shift_a_s;
  logic [CNT_W-1:0]      cnt_b_s;
  logic [CNT_W-1:0]      cnt_bw_s;
  logic [CNT_W-1:0]      cnt_a_s;
  logic [CNT_W-1:0]      cnt_next_s;
  logic                  full_b_s;
  logic                  full_a_s;
  logic                  word_done_s;
  logic [DATA_WIDTH-1:0] word_next_s;

  logic [DATA_WIDTH-1:0] pend_data_s;
  logic                  pend_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic                  out_valid_s;
  logic                  out_last_s;

  logic                  armed_s;
  logic [1:0]            end_cnt_s;
  logic [1:0]            end_inc_s;
  logic                  end_frame_s;
  logic                  end_frame_error_s;

  // The SDCKB-fall bit is applied first, so a same-cycle pair lands in arrival order.
  assign shift_b_s   = sdckb_negedge ? {shift_r[DATA_WIDTH-2:0], sdcka_data} : shift_r;
  assign cnt_b_s     = bit_cnt_r + CNT_W'(sdckb_negedge);
  assign full_b_s    = (cnt_b_s == FULL_CNT);
  assign cnt_bw_s    = full_b_s ? ZERO_CNT : cnt_b_s;
  assign shift_a_s   = sdcka_negedge ? {shift_b_s[DATA_WIDTH-2:0], sdckb_data} : shift_b_s;
  assign cnt_a_s     = cnt_bw_s + CNT_W'(sdcka_negedge);
  assign full_a_s    = (cnt_a_s == FULL_CNT);
  assign cnt_next_s  = full_a_s ? ZERO_CNT : cnt_a_s;
  assign word_done_s = full_b_s | full_a_s;
  assign word_next_s = full_b_s ? shift_b_s : shift_a_s;

  // Decoder state: shifter, bit counter and the one-cycle internal word strobe
  always_ff @(posedge aclk) begin
    if (areset) begin
      shift_r    <= {DATA_WIDTH{1'b0}};
      bit_cnt_r  <= ZERO_CNT;
      word_stb_r <= 1'b0;
      word_r     <= {DATA_WIDTH{1'b0}};
    end else if (enable) begin
      shift_r    <= shift_a_s;
      bit_cnt_r  <= cnt_next_s;
      word_stb_r <= word_done_s;
      word_r     <= word_done_s ? word_next_s : word_r;
    end else begin
      shift_r    <= {DATA_WIDTH{1'b0}};
      bit_cnt_r  <= ZERO_CNT;
      word_stb_r <= 1'b0;
      word_r     <= word_r;
    end
  end

  // Hold-back slot: a word is only released once its successor or the frame end is known
  always_comb begin
    pend_data_s  = pend_data_r;
    pend_valid_s = pend_valid_r;
    out_data_s   = m_tdata_r;
    out_valid_s  = 1'b0;
    out_last_s   = 1'b0;
    if (enable_q_r && !enable) begin
      out_valid_s  = pend_valid_r;
      out_last_s   = pend_valid_r;
      out_data_s   = pend_valid_r ? pend_data_r : m_tdata_r;
      pend_valid_s = 1'b0;
    end else if (enable && !enable_q_r) begin
      pend_valid_s = 1'b0;
    end else if (word_stb_r) begin
      out_valid_s  = pend_valid_r;
      out_data_s   = pend_valid_r ? pend_data_r : m_tdata_r;
      pend_data_s  = word_r;
      pend_valid_s = 1'b1;
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // Buffer and stream output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      enable_q_r   <= 1'b0;
      pend_data_r  <= {DATA_WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
      m_tdata_r    <= {DATA_WIDTH{1'b0}};
      m_tvalid_r   <= 1'b0;
      m_tlast_r    <= 1'b0;
      m_tstrb_r    <= {KEEP_W{1'b0}};
    end else begin
      enable_q_r   <= enable;
      pend_data_r  <= pend_data_s;
      pend_valid_r <= pend_valid_s;
      m_tdata_r    <= out_data_s;
      m_tvalid_r   <= out_valid_s;
      m_tlast_r    <= out_last_s;
      m_tstrb_r    <= {KEEP_W{out_valid_s}};
    end
  end

  assign end_inc_s = (end_cnt_r == 2'd3) ? 2'd3 : end_cnt_r + 2'd1;

  // End-pattern detector: an A fall arms, B falls are counted, the A rise judges the count
  always_comb begin
    armed_s           = armed_r;
    end_cnt_s         = end_cnt_r;
    end_frame_s       = 1'b0;
    end_frame_error_s = 1'b0;
    if (sdcka_negedge) begin
      armed_s   = 1'b1;
      end_cnt_s = 2'd0;
    end else if (armed_r) begin
      end_cnt_s = sdckb_negedge ? end_inc_s : end_cnt_r;
      if (sdcka_posedge) begin
        armed_s = 1'b0;
`ifdef MAPLE_END_ERR_EN
        end_frame_s       = (end_cnt_s == 2'd2);
        end_frame_error_s = (end_cnt_s == 2'd3);
`else
        end_frame_s       = (end_cnt_s >= 2'd2);
        end_frame_error_s = 1'b0;
`endif
      end else begin
        armed_s = 1'b1;
      end
    end else begin
      armed_s = 1'b0;
    end
  end

  // End-pattern detector registers and pulse outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      armed_r           <= 1'b0;
      end_cnt_r         <= 2'd0;
      end_frame_r       <= 1'b0;
      end_frame_error_r <= 1'b0;
    end else begin
      armed_r           <= armed_s;
      end_cnt_r         <= end_cnt_s;
      end_frame_r       <= end_frame_s;
      end_frame_error_r <= end_frame_error_s;
    end
  end

  assign m_tdata         = m_tdata_r;
  assign m_tvalid        = m_tvalid_r;
  assign m_tlast         = m_tlast_r;
  assign m_tstrb         = m_tstrb_r;
  assign m_tkeep         = m_tstrb_r;
  assign end_frame       = end_frame_r;
  assign end_frame_error = end_frame_error_r;

endmodule

// File: tb/tb_maple_rx_datapath.sv
// Randomized scoreboard bench for maple_rx_datapath; expected words and end pulses carry their arrival cycle.
module tb_maple_rx_datapath;

  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic          sdcka_data = 1'b0;
  logic          sdcka_posedge = 1'b0;
  logic          sdcka_negedge = 1'b0;
  logic          sdckb_data = 1'b0;
  logic          sdckb_negedge = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic [0:0]    m_tstrb;
  logic [0:0]    m_tkeep;
  logic          m_tlast;
  logic          end_frame;
  logic          end_frame_error;

  maple_rx_datapath #(.DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_negedge(sdckb_negedge),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .end_frame(end_frame), .end_frame_error(end_frame_error)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic last; int cyc; } wexp_t;
  typedef struct { logic [1:0] code; int cyc; } eexp_t;
  wexp_t wq[$];
  eexp_t eq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: bits collected in the current frame
  logic          en_cur = 1'b0;
  logic          en_prev = 1'b0;
  logic [DW-1:0] cur = '0;
  int            nb = 0;
  logic [DW-1:0] pend = '0;
  bit            have_pend = 1'b0;
  int            last_comp = -100;
  int            last_k = 0;
  bit            a_turn = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input logic l, input int c);
    wexp_t e;
    e.data = d; e.last = l; e.cyc = c;
    wq.push_back(e);
  endtask

  task automatic add_bit(input logic b, input int k);
    cur = {cur[DW-2:0], b};
    nb++;
    if (nb == DW) begin
      nb = 0;
      if (have_pend) push_word(pend, 1'b0, k + 2);
      pend = cur;
      have_pend = 1'b1;
      last_comp = k;
    end
  endtask

  // enable fell at stimulus cycle k: the held word ends the frame unless its successor collides with the flush
  task automatic flush(input int k);
    wexp_t t;
    if (have_pend) begin
      if (last_comp == k - 1) begin
        if (wq.size() > 0 && wq[wq.size()-1].cyc == k + 1) begin
          t = wq.pop_back();
          t.last = 1'b1;
          wq.push_back(t);
        end
      end else begin
        push_word(pend, 1'b1, k + 1);
      end
    end
    have_pend = 1'b0;
    nb = 0;
  endtask

  task automatic drive(input logic en, input logic an, input logic bn, input logic ap,
                       input logic ad, input logic bd, input logic rst);
    int k;
    k = cyc;
    enable = en; sdcka_negedge = an; sdckb_negedge = bn; sdcka_posedge = ap;
    sdcka_data = ad; sdckb_data = bd; areset = rst;
    if (rst) begin
      have_pend = 1'b0; nb = 0; en_prev = 1'b0;
    end else begin
      if (!en && en_prev) flush(k);
      if (en && !en_prev) begin nb = 0; have_pend = 1'b0; last_comp = -100; end
      if (en) begin
        if (bn) add_bit(ad, k);
        if (an) add_bit(bd, k);
      end
      en_prev = en;
    end
    last_k = k;
    @(posedge aclk);
    #1;
    sdcka_negedge = 1'b0; sdckb_negedge = 1'b0; sdcka_posedge = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(en_cur, 1'b0, 1'b0, 1'b0, rb(), rb(), 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit pairs, input bit gaps);
    int i;
    i = n - 1;
    while (i >= 0) begin
      if (pairs && i >= 1 && $urandom_range(0, 3) == 0) begin
        drive(en_cur, 1'b1, 1'b1, 1'b0, v[i], v[i-1], 1'b0);
        i -= 2;
      end else begin
        if (a_turn) drive(en_cur, 1'b1, 1'b0, 1'b0, rb(), v[i], 1'b0);
        else        drive(en_cur, 1'b0, 1'b1, 1'b0, v[i], rb(), 1'b0);
        a_turn = !a_turn;
        i--;
      end
      if (gaps) idle($urandom_range(0, 1));
    end
  endtask

  // A fall, nbf counted B falls, A rise; the B fall beside the A fall never counts
  task automatic end_seq(input int nbf, input bit b_fall, input bit b_rise);
    int   cnt;
    eexp_t e;
    drive(en_cur, 1'b1, b_fall, 1'b0, rb(), rb(), 1'b0);
    for (int i = 0; i < nbf; i++) begin
      idle($urandom_range(0, 1));
      drive(en_cur, 1'b0, 1'b1, 1'b0, rb(), rb(), 1'b0);
    end
    idle($urandom_range(0, 1));
    drive(en_cur, 1'b0, b_rise, 1'b1, rb(), rb(), 1'b0);
    cnt = nbf + int'(b_rise);
    if (cnt >= 2) begin
`ifdef MAPLE_END_ERR_EN
      e.code = (cnt >= 3) ? 2'b10 : 2'b01;
`else
      e.code = 2'b01;
`endif
      e.cyc = last_k + 1;
      eq.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input int n);
    en_cur = 1'b1;
    idle(2);
    if (n > 0) send_bits(32'(w0), DW, 1'b0, 1'b0);
    if (n > 1) send_bits(32'(w1), DW, 1'b0, 1'b0);
    if (n > 2) send_bits(32'(w2), DW, 1'b0, 1'b0);
    idle(2);
    en_cur = 1'b0;
    idle(3);
  endtask

  // monitor: pop and compare whenever the DUT presents a word or an end pulse
  always @(negedge aclk) begin
    wexp_t w;
    eexp_t e;
    chk("strb", 64'(m_tstrb), m_tvalid ? 64'd1 : 64'd0);
    chk("keep", 64'(m_tkeep), m_tvalid ? 64'd1 : 64'd0);
    chk("last_without_valid", 64'(m_tlast & ~m_tvalid), 64'd0);
    if (m_tvalid) begin
      if (wq.size() == 0) begin
        chk("unexpected_word", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("word_data", 64'(m_tdata), 64'(w.data));
        chk("word_last", 64'(m_tlast), 64'(w.last));
        chk("word_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
    if (end_frame || end_frame_error) begin
      if (eq.size() == 0) begin
        chk("unexpected_end_pulse", 64'({end_frame_error, end_frame}), 64'd0);
      end else begin
        e = eq.pop_front();
        chk("end_kind", 64'({end_frame_error, end_frame}), 64'(e.code));
        chk("end_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tstrb", 64'(m_tstrb), 64'd0);
    chk("rst_end_frame", 64'(end_frame), 64'd0);
    chk("rst_end_frame_error", 64'(end_frame_error), 64'd0);
    idle(2);

    send_frame(8'hA5, 8'h00, 8'h00, 1);
    send_frame(8'h12, 8'h34, 8'h56, 3);

    end_seq(2, 1'b0, 1'b0);
    idle(2);
    end_seq(1, 1'b0, 1'b0);
    end_seq(3, 1'b0, 1'b0);
    end_seq(1, 1'b0, 1'b1);
    end_seq(2, 1'b1, 1'b0);
    end_seq(1, 1'b1, 1'b0);
    drive(en_cur, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // partial word discarded across a disable
    en_cur = 1'b1;
    idle(1);
    send_bits(32'h1B, 5, 1'b0, 1'b0);
    idle(1);
    en_cur = 1'b0;
    idle(2);
    send_frame(8'h3C, 8'h00, 8'h00, 1);

    // reset with a word pending and a partial word in the shifter
    en_cur = 1'b1;
    idle(1);
    send_bits(32'h77, DW, 1'b0, 1'b0);
    send_bits(32'h5, 3, 1'b0, 1'b0);
    idle(3);
    en_cur = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h5A, 8'hC3, 8'h00, 2);

    for (int f = 0; f < 40; f++) begin
      en_cur = 1'b1;
      idle($urandom_range(1, 2));
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        send_bits($urandom, DW, 1'b1, 1'b1);
        if ($urandom_range(0, 7) == 0) end_seq($urandom_range(0, 4), rb(), rb());
      end
      if (rb()) send_bits($urandom, $urandom_range(1, DW - 1), 1'b1, 1'b1);
      idle($urandom_range(0, 3));
      en_cur = 1'b0;
      idle(1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        drive(1'b0, rb(), rb(), 1'b0, rb(), rb(), 1'b0);
      if (rb()) begin
        end_seq($urandom_range(0, 4), rb(), rb());
        if (rb()) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle(1);
    end

    idle(6);
    chk("word_queue_drained", 64'(wq.size()), 64'd0);
    chk("end_queue_drained", 64'(eq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
